// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the memory-stage controller and the 16-bit data RAM.
//   o_mem_addr  : word address (AddrWidth bits), driven by the controller
//   o_mem_wdata : write data, driven by the controller
//   o_mem_we    : write strobe, driven by the controller
//   o_mem_re    : read strobe, driven by the controller
//   i_mem_rdata : asynchronous read data, driven by the memory
// master = controller side, slave = memory side.
interface mem_stage_ctrl_if #(
  parameter int AddrWidth = 11
);
  logic [AddrWidth-1:0] o_mem_addr;
  logic [15:0]          o_mem_wdata;
  logic                 o_mem_we;
  logic                 o_mem_re;
  logic [15:0]          i_mem_rdata;

  modport master (
    output o_mem_addr,
    output o_mem_wdata,
    output o_mem_we,
    output o_mem_re,
    input  i_mem_rdata
  );

  modport slave (
    input  o_mem_addr,
    input  o_mem_wdata,
    input  o_mem_we,
    input  o_mem_re,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller.
// Consumes the registered ALU/Mem buffer outputs, drives the 16-bit data
// memory, owns the stack pointer and sequences 32-bit PC push/pop as two
// 16-bit accesses, stalling the upstream buffer for one cycle meanwhile.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_Mem          : [0] read, [1] write, [2] push, [3] pop, [4] wide, [5] wdata_sel
//   i_WB/o_WB      : writeback control (o_WB zeroed in the stalled cycle)
//   i_pc           : PC from buffer (stored by push, low half by sel=1 stores)
//   i_Rdst/o_Rdst  : destination register pass-through
//   i_alu          : ALU result / effective address
//   i_read_data1   : store data
//   i_flag/o_flag  : flag pass-through
//   mem            : data-memory bus (master side)
//   o_stall        : hold upstream buffer for one more cycle
//   o_result       : memory read data on reads, otherwise i_alu
//   o_pc_load      : one-cycle pulse, load o_pc_value into the PC
//   o_pc_value     : PC reassembled from a wide pop
//   o_sp           : current stack pointer
module mem_stage_ctrl #(
  parameter int                 WbSize    = 2,
  parameter int                 MemSize   = 6,
  parameter int                 flagSize  = 4,
  parameter int                 AddrWidth = 11,
  parameter logic [AddrWidth-1:0] SpInit  = 11'h7FF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MemSize-1:0]   i_Mem,
  input  logic [WbSize-1:0]    i_WB,
  input  logic [31:0]          i_pc,
  input  logic [2:0]           i_Rdst,
  input  logic [15:0]          i_alu,
  input  logic [15:0]          i_read_data1,
  input  logic [flagSize-1:0]  i_flag,
  mem_stage_ctrl_if.master     mem,
  output logic                 o_stall,
  output logic [15:0]          o_result,
  output logic [WbSize-1:0]    o_WB,
  output logic [2:0]           o_Rdst,
  output logic [flagSize-1:0]  o_flag,
  output logic                 o_pc_load,
  output logic [31:0]          o_pc_value,
  output logic [AddrWidth-1:0] o_sp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH2 = 2'd1,
    POP2  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [AddrWidth-1:0] sp;
  logic [AddrWidth-1:0] sp_nxt;
  logic [15:0]          hold;
  logic [15:0]          hold_nxt;

  // Control field decode
  logic mem_read;
  logic mem_write;
  logic push;
  logic pop;
  logic wide;
  logic wdata_sel;
  logic push_op;
  logic pop_op;

  assign mem_read  = i_Mem[0];
  assign mem_write = i_Mem[1];
  assign push      = i_Mem[2];
  assign pop       = i_Mem[3];
  assign wide      = i_Mem[4];
  assign wdata_sel = i_Mem[5];

  // Conflicting push+pop is treated as neither: the op falls back to a
  // plain access at i_alu.
  assign push_op = push & ~pop;
  assign pop_op  = pop & ~push;

  // Stack arithmetic wraps modulo 2^AddrWidth by construction.
  logic [AddrWidth-1:0] sp_inc;
  logic [AddrWidth-1:0] sp_dec;
  assign sp_inc = sp + AddrWidth'(1);
  assign sp_dec = sp - AddrWidth'(1);

  logic [15:0] store_data;
  assign store_data = wdata_sel ? i_pc[15:0] : i_read_data1;

  // Combinational access decode
  logic [AddrWidth-1:0] addr_c;
  logic [15:0]          wdata_c;
  logic                 we_c;
  logic                 re_c;
  logic                 stall_c;
  logic                 pc_load_c;
  logic [31:0]          pc_value_c;

  always_comb begin
    addr_c     = i_alu[AddrWidth-1:0];
    wdata_c    = store_data;
    we_c       = mem_write;
    re_c       = mem_read & ~mem_write;   // write wins when both are set
    stall_c    = 1'b0;
    pc_load_c  = 1'b0;
    pc_value_c = 32'h0;
    state_nxt  = state;
    sp_nxt     = sp;
    hold_nxt   = hold;

    unique case (state)
      IDLE: begin
        if (push_op) begin
          addr_c = sp;
          we_c   = 1'b1;
          re_c   = 1'b0;
          sp_nxt = sp_dec;
          if (wide) begin
            // High half goes to the higher address first.
            wdata_c   = i_pc[31:16];
            stall_c   = 1'b1;
            state_nxt = PUSH2;
          end
        end else if (pop_op) begin
          addr_c = sp_inc;
          we_c   = 1'b0;
          re_c   = 1'b1;
          sp_nxt = sp_inc;
          if (wide) begin
            // Low half sits at the lower address and comes back first.
            hold_nxt  = mem.i_mem_rdata;
            stall_c   = 1'b1;
            state_nxt = POP2;
          end
        end
      end
      PUSH2: begin
        // Buffer is held, so i_pc still carries the same PC.
        addr_c    = sp;
        wdata_c   = i_pc[15:0];
        we_c      = 1'b1;
        re_c      = 1'b0;
        sp_nxt    = sp_dec;
        state_nxt = IDLE;
      end
      POP2: begin
        addr_c     = sp_inc;
        we_c       = 1'b0;
        re_c       = 1'b1;
        pc_value_c = {mem.i_mem_rdata, hold};
        pc_load_c  = 1'b1;
        sp_nxt     = sp_inc;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, SP and low-half holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sp    <= SpInit;
      hold  <= 16'h0;
    end else begin
      state <= state_nxt;
      sp    <= sp_nxt;
      hold  <= hold_nxt;
    end
  end

  // Output drive; reset masks every side effect, which also aborts a
  // wide op caught mid-way.
  assign mem.o_mem_addr  = addr_c;
  assign mem.o_mem_wdata = wdata_c;
  assign mem.o_mem_we    = we_c & ~rst;
  assign mem.o_mem_re    = re_c & ~rst;

  assign o_stall    = stall_c & ~rst;
  assign o_pc_load  = pc_load_c & ~rst;
  assign o_pc_value = rst ? 32'h0 : pc_value_c;
  assign o_result   = re_c ? mem.i_mem_rdata : i_alu;

  // Writeback is suppressed in the stalled cycle so the held instruction
  // retires exactly once.
  assign o_WB   = o_stall ? '0 : i_WB;
  assign o_Rdst = i_Rdst;
  assign o_flag = i_flag;
  assign o_sp   = sp;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  i_Mem;
  logic [1:0]  i_WB;
  logic [31:0] i_pc;
  logic [2:0]  i_Rdst;
  logic [15:0] i_alu;
  logic [15:0] i_read_data1;
  logic [3:0]  i_flag;
  logic        o_stall;
  logic [15:0] o_result;
  logic [1:0]  o_WB;
  logic [2:0]  o_Rdst;
  logic [3:0]  o_flag;
  logic        o_pc_load;
  logic [31:0] o_pc_value;
  logic [10:0] o_sp;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage_ctrl_if #(.AddrWidth(11)) bus ();

  mem_stage_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .i_Mem        (i_Mem),
    .i_WB         (i_WB),
    .i_pc         (i_pc),
    .i_Rdst       (i_Rdst),
    .i_alu        (i_alu),
    .i_read_data1 (i_read_data1),
    .i_flag       (i_flag),
    .mem          (bus.master),
    .o_stall      (o_stall),
    .o_result     (o_result),
    .o_WB         (o_WB),
    .o_Rdst       (o_Rdst),
    .o_flag       (o_flag),
    .o_pc_load    (o_pc_load),
    .o_pc_value   (o_pc_value),
    .o_sp         (o_sp)
  );

  always #5 clk = ~clk;

  // Data memory: asynchronous read, synchronous write.
  logic [15:0] ram [0:2047];
  assign bus.i_mem_rdata = ram[bus.o_mem_addr];
  always @(posedge clk) if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;

  task automatic drive(input logic [5:0] m, input logic [15:0] alu,
                       input logic [15:0] rd1, input logic [31:0] pc,
                       input logic [1:0] wb);
    i_Mem = m; i_alu = alu; i_read_data1 = rd1; i_pc = pc; i_WB = wb;
    #3;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(6'b010100, 16'h0, 16'h0, 32'hABCD0042, 2'b11);
    step(); step();
    n_cmp++; if (o_sp !== 11'h7FF) begin n_fail++; $display("FAIL rst_sp got %h want 7ff", o_sp); end
    n_cmp++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", o_stall); end
    n_cmp++; if ({bus.o_mem_we, bus.o_mem_re} !== 2'b00) begin n_fail++; $display("FAIL rst_we_re got %b want 00", {bus.o_mem_we, bus.o_mem_re}); end
    n_cmp++; if (o_pc_load !== 1'b0) begin n_fail++; $display("FAIL rst_pc_load got %b want 0", o_pc_load); end
    rst = 1'b0;
    drive(6'b000000, 16'h0, 16'h0, 32'h0, 2'b00);
    step();
  endtask

  task automatic test_plain();
    i_Rdst = 3'd5; i_flag = 4'hA;
    drive(6'b000010, 16'h0010, 16'hBEEF, 32'h0, 2'b01);
    n_cmp++; if ({bus.o_mem_we, bus.o_mem_re} !== 2'b10) begin n_fail++; $display("FAIL st_we_re got %b want 10", {bus.o_mem_we, bus.o_mem_re}); end
    n_cmp++; if (bus.o_mem_addr !== 11'h010) begin n_fail++; $display("FAIL st_addr got %h want 010", bus.o_mem_addr); end
    n_cmp++; if (bus.o_mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL st_wdata got %h want beef", bus.o_mem_wdata); end
    n_cmp++; if ({o_Rdst, o_flag, o_WB} !== {3'd5, 4'hA, 2'b01}) begin n_fail++; $display("FAIL passthru got %h want %h", {o_Rdst, o_flag, o_WB}, {3'd5, 4'hA, 2'b01}); end
    step();
    drive(6'b000001, 16'h0010, 16'h0, 32'h0, 2'b01);
    n_cmp++; if (bus.o_mem_re !== 1'b1) begin n_fail++; $display("FAIL ld_re got %b want 1", bus.o_mem_re); end
    n_cmp++; if (o_result !== 16'hBEEF) begin n_fail++; $display("FAIL ld_result got %h want beef", o_result); end
    step();
    n_cmp++; if (o_sp !== 11'h7FF) begin n_fail++; $display("FAIL ld_sp got %h want 7ff", o_sp); end
    // Non-read passes the ALU value through; sel=1 stores pc[15:0].
    drive(6'b100010, 16'h0044, 16'h1111, 32'h9999_7777, 2'b00);
    n_cmp++; if (bus.o_mem_wdata !== 16'h7777) begin n_fail++; $display("FAIL st_sel_wdata got %h want 7777", bus.o_mem_wdata); end
    n_cmp++; if (o_result !== 16'h0044) begin n_fail++; $display("FAIL st_result got %h want 0044", o_result); end
    step();
  endtask

  task automatic test_push_pop16();
    drive(6'b000100, 16'h0, 16'h1234, 32'h0, 2'b00);
    n_cmp++; if (bus.o_mem_addr !== 11'h7FF) begin n_fail++; $display("FAIL push_addr got %h want 7ff", bus.o_mem_addr); end
    n_cmp++; if ({bus.o_mem_we, bus.o_mem_wdata} !== {1'b1, 16'h1234}) begin n_fail++; $display("FAIL push_we_wdata got %h want 11234", {bus.o_mem_we, bus.o_mem_wdata}); end
    step();
    n_cmp++; if (o_sp !== 11'h7FE) begin n_fail++; $display("FAIL push_sp got %h want 7fe", o_sp); end
    drive(6'b001000, 16'h0, 16'h0, 32'h0, 2'b00);
    n_cmp++; if ({bus.o_mem_re, bus.o_mem_we, bus.o_mem_addr} !== {2'b10, 11'h7FF}) begin n_fail++; $display("FAIL pop_re_we_addr got %h want %h", {bus.o_mem_re, bus.o_mem_we, bus.o_mem_addr}, {2'b10, 11'h7FF}); end
    n_cmp++; if (o_result !== 16'h1234) begin n_fail++; $display("FAIL pop_result got %h want 1234", o_result); end
    step();
    n_cmp++; if (o_sp !== 11'h7FF) begin n_fail++; $display("FAIL pop_sp got %h want 7ff", o_sp); end
  endtask

  task automatic test_wide_push();
    drive(6'b010100, 16'h0, 16'h0, 32'hABCD0042, 2'b11);
    n_cmp++; if ({bus.o_mem_addr, bus.o_mem_wdata} !== {11'h7FF, 16'hABCD}) begin n_fail++; $display("FAIL wpush1_addr_wdata got %h want %h", {bus.o_mem_addr, bus.o_mem_wdata}, {11'h7FF, 16'hABCD}); end
    n_cmp++; if ({bus.o_mem_we, o_stall, o_WB} !== 4'b1100) begin n_fail++; $display("FAIL wpush1_we_stall_wb got %b want 1100", {bus.o_mem_we, o_stall, o_WB}); end
    step();
    #3;
    n_cmp++; if ({bus.o_mem_addr, bus.o_mem_wdata} !== {11'h7FE, 16'h0042}) begin n_fail++; $display("FAIL wpush2_addr_wdata got %h want %h", {bus.o_mem_addr, bus.o_mem_wdata}, {11'h7FE, 16'h0042}); end
    n_cmp++; if ({bus.o_mem_we, o_stall, o_WB} !== 4'b1011) begin n_fail++; $display("FAIL wpush2_we_stall_wb got %b want 1011", {bus.o_mem_we, o_stall, o_WB}); end
    step();
    drive(6'b000000, 16'h0, 16'h0, 32'h0, 2'b00);
    n_cmp++; if ({o_sp, o_stall} !== {11'h7FD, 1'b0}) begin n_fail++; $display("FAIL wpush_sp got %h want %h", {o_sp, o_stall}, {11'h7FD, 1'b0}); end
  endtask

  task automatic test_wide_pop();
    drive(6'b011000, 16'h0, 16'h0, 32'h0, 2'b10);
    n_cmp++; if ({bus.o_mem_addr, bus.o_mem_re} !== {11'h7FE, 1'b1}) begin n_fail++; $display("FAIL wpop1_addr_re got %h want %h", {bus.o_mem_addr, bus.o_mem_re}, {11'h7FE, 1'b1}); end
    n_cmp++; if ({o_stall, o_pc_load, o_WB} !== 4'b1000) begin n_fail++; $display("FAIL wpop1_stall_load_wb got %b want 1000", {o_stall, o_pc_load, o_WB}); end
    step();
    #3;
    n_cmp++; if ({bus.o_mem_addr, o_stall, o_pc_load} !== {11'h7FF, 2'b01}) begin n_fail++; $display("FAIL wpop2_addr_stall_load got %h want %h", {bus.o_mem_addr, o_stall, o_pc_load}, {11'h7FF, 2'b01}); end
    n_cmp++; if (o_pc_value !== 32'hABCD0042) begin n_fail++; $display("FAIL wpop2_pc_value got %h want abcd0042", o_pc_value); end
    n_cmp++; if (o_WB !== 2'b10) begin n_fail++; $display("FAIL wpop2_wb got %b want 10", o_WB); end
    step();
    drive(6'b000000, 16'h0, 16'h0, 32'h0, 2'b00);
    n_cmp++; if ({o_sp, o_pc_load} !== {11'h7FF, 1'b0}) begin n_fail++; $display("FAIL wpop_sp_load got %h want %h", {o_sp, o_pc_load}, {11'h7FF, 1'b0}); end
  endtask

  task automatic test_wrap();
    drive(6'b001000, 16'h0, 16'h0, 32'h0, 2'b00);
    n_cmp++; if (bus.o_mem_addr !== 11'h000) begin n_fail++; $display("FAIL wrap_pop_addr got %h want 000", bus.o_mem_addr); end
    step();
    n_cmp++; if (o_sp !== 11'h000) begin n_fail++; $display("FAIL wrap_pop_sp got %h want 000", o_sp); end
    drive(6'b000100, 16'h0, 16'h5A5A, 32'h0, 2'b00);
    n_cmp++; if (bus.o_mem_addr !== 11'h000) begin n_fail++; $display("FAIL wrap_push_addr got %h want 000", bus.o_mem_addr); end
    step();
    n_cmp++; if (o_sp !== 11'h7FF) begin n_fail++; $display("FAIL wrap_push_sp got %h want 7ff", o_sp); end
  endtask

  task automatic test_reset_pop2();
    drive(6'b011000, 16'h0, 16'h0, 32'h0, 2'b00);
    step();
    rst = 1'b1;
    #3;
    n_cmp++; if ({o_pc_load, o_stall, bus.o_mem_re, bus.o_mem_we} !== 4'b0000) begin n_fail++; $display("FAIL rstpop2_outs got %b want 0000", {o_pc_load, o_stall, bus.o_mem_re, bus.o_mem_we}); end
    step();
    rst = 1'b0;
    drive(6'b000000, 16'h0, 16'h0, 32'h0, 2'b00);
    n_cmp++; if ({o_sp, o_pc_load, o_stall} !== {11'h7FF, 2'b00}) begin n_fail++; $display("FAIL rstpop2_idle got %h want %h", {o_sp, o_pc_load, o_stall}, {11'h7FF, 2'b00}); end
    step();
    n_cmp++; if (o_sp !== 11'h7FF) begin n_fail++; $display("FAIL rstpop2_sp_hold got %h want 7ff", o_sp); end
  endtask

  task automatic test_conflicts();
    drive(6'b000011, 16'h0020, 16'h5555, 32'h0, 2'b00);
    n_cmp++; if ({bus.o_mem_we, bus.o_mem_re, bus.o_mem_addr} !== {2'b10, 11'h020}) begin n_fail++; $display("FAIL rw_both got %h want %h", {bus.o_mem_we, bus.o_mem_re, bus.o_mem_addr}, {2'b10, 11'h020}); end
    step();
    drive(6'b001110, 16'h0030, 16'h6666, 32'h0, 2'b00);
    n_cmp++; if ({bus.o_mem_we, bus.o_mem_addr} !== {1'b1, 11'h030}) begin n_fail++; $display("FAIL pushpop_addr got %h want %h", {bus.o_mem_we, bus.o_mem_addr}, {1'b1, 11'h030}); end
    step();
    n_cmp++; if (o_sp !== 11'h7FF) begin n_fail++; $display("FAIL pushpop_sp got %h want 7ff", o_sp); end
    drive(6'b010010, 16'h0040, 16'h7777, 32'h0, 2'b11);
    n_cmp++; if ({o_stall, bus.o_mem_we, bus.o_mem_addr, o_WB} !== {2'b01, 11'h040, 2'b11}) begin n_fail++; $display("FAIL wide_plain got %h want %h", {o_stall, bus.o_mem_we, bus.o_mem_addr, o_WB}, {2'b01, 11'h040, 2'b11}); end
    step();
    drive(6'b000000, 16'h0, 16'h0, 32'h0, 2'b00);
    n_cmp++; if (o_sp !== 11'h7FF) begin n_fail++; $display("FAIL wide_plain_sp got %h want 7ff", o_sp); end
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) ram[k] = 16'h0;
    rst = 1'b1; i_Mem = '0; i_WB = '0; i_pc = '0; i_Rdst = '0;
    i_alu = '0; i_read_data1 = '0; i_flag = '0;
    @(negedge clk);
    test_reset();
    test_plain();
    test_push_pop16();
    test_wide_push();
    test_wide_pop();
    test_wrap();
    test_reset_pop2();
    test_conflicts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller; consumes the registered outputs of the ALU/Mem pipeline buffer: control bits, ALU result, store data, PC, Rdst, WB and flags.
- Drives the 16-bit data memory and owns the stack pointer (SP).
- Sequences 32-bit PC push/pop as two 16-bit accesses.
- Stalls upstream via o_stall, which feeds the buffer enable inverted, so the buffer holds its contents for a second cycle.

Parameters:
- WbSize, 2, width of WB control field passed through.
- MemSize, 6, width of Mem control field.
- flagSize, 4, width of flag field.
- AddrWidth, 11, data-memory address width; SP width.
- SpInit, 11'h7FF, SP value after reset (top of memory).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- i_Mem  input  MemSize  [0] mem_read, [1] mem_write, [2] push, [3] pop, [4] wide (32-bit PC transfer), [5] wdata_sel (0 read_data1, 1 pc).
- i_WB  input  WbSize  writeback control from buffer.
- i_pc  input  32  PC from buffer.
- i_Rdst  input  3  destination register.
- i_alu  input  16  ALU result / effective address.
- i_read_data1  input  16  store data.
- i_flag  input  flagSize  flags from buffer.
- i_mem_rdata  input  16  memory read data (asynchronous read, same cycle).
- o_mem_addr  output  AddrWidth  memory address.
- o_mem_wdata  output  16  memory write data.
- o_mem_we  output  1  memory write strobe.
- o_mem_re  output  1  memory read strobe.
- o_stall  output  1  hold upstream buffer (buffer enable = ~o_stall).
- o_result  output  16  data to MEM/WB: memory data if read, else i_alu.
- o_WB  output  WbSize  i_WB passed through; forced 0 while o_stall=1.
- o_Rdst  output  3  i_Rdst passed through.
- o_flag  output  flagSize  i_flag passed through.
- o_pc_load  output  1  one-cycle pulse: load o_pc_value into PC.
- o_pc_value  output  32  PC popped from stack.
- o_sp  output  AddrWidth  current SP (registered).

Behaviour:
- FSM states: IDLE, PUSH2, POP2. State, SP and the low-half holding register are registered on posedge clk.
- Reset (rst=1 at posedge): state=IDLE, SP=SpInit, hold register=0.
- Combinational outputs under reset: o_stall=0, o_mem_we=0, o_mem_re=0, o_pc_load=0, o_pc_value=0.
- Reset mid wide op: aborts it; no second access, no o_pc_load.
- Address wrap: SP arithmetic is modulo 2^AddrWidth. SpInit+1 wraps to 0. 0-1 wraps to all-ones.
- IDLE, no push/pop: plain access at addr i_alu[AddrWidth-1:0], 1-cycle latency.
  - mem_write: we=1, wdata per wdata_sel (sel=1 uses pc[15:0]).
  - mem_read: re=1, o_result=i_mem_rdata.
  - read and write both set: write only, re=0.
- IDLE, push, wide=0: we=1 at addr=SP, wdata per sel; SP<=SP-1.
- IDLE, pop, wide=0: re=1 at addr=SP+1, o_result=i_mem_rdata; SP<=SP+1.
- push and pop both set: both ignored; treated as plain access at i_alu.
- IDLE, push, wide=1: cycle 1 writes pc[31:16] at SP, o_stall=1, SP<=SP-1, ->PUSH2.
- PUSH2: writes pc[15:0] at SP (buffer held, same i_pc), o_stall=0, SP<=SP-1, ->IDLE.
- IDLE, pop, wide=1: cycle 1 reads at SP+1, hold<=i_mem_rdata (low half), o_stall=1, SP<=SP+1, ->POP2.
- POP2: reads at SP+1, o_pc_value={i_mem_rdata, hold}, o_pc_load=1, SP<=SP+1, o_stall=0, ->IDLE.
- Wide op total: 2 cycles, exactly one stall cycle. o_WB=0 in the stalled cycle so writeback fires once.
- wide=1 without push or pop: ignored as wide; plain access.

Test Plan:
- Reset: assert rst 2 cycles -> o_sp=0x7FF, o_stall=0, we=re=0, o_pc_load=0.
- Plain store then load: write alu=0x0010, rd1=0xBEEF -> we=1, addr=0x010, wdata=0xBEEF. Then read same address -> o_result=0xBEEF, o_sp unchanged.
- Push/pop 16-bit: push 0x1234 -> write @0x7FF, sp=0x7FE. Pop -> read @0x7FF, result=0x1234, sp=0x7FF.
- Wide push pc=0xABCD0042 from sp=0x7FF -> 0xABCD @0x7FF with stall=1, then 0x0042 @0x7FE with stall=0; sp=0x7FD; o_WB=0 in first cycle.
- Wide pop from sp=0x7FD -> reads 0x7FE then 0x7FF; o_pc_load=1 for one cycle with o_pc_value=0xABCD0042; sp=0x7FF; one stall cycle.
- Edge cases:
  - sp=0x7FF single pop -> addr wraps to 0x000, sp=0x000.
  - rst asserted in POP2 -> no o_pc_load, state IDLE, sp=0x7FF.
  - read+write both set -> only we=1.
